// File: rtl/ddr_data_sequencer_pkg.sv
// Shared definitions for the DDR data sequencer: IOB widths and FSM state encoding.
package ddr_data_sequencer_pkg;

  localparam int IOB_WIDTH = 32;
  localparam int DQ_WIDTH  = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WRITE   = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_READ    = 3'd3,
    ST_TURN    = 3'd4
  } state_e;

endpackage

// File: rtl/ddr_capture_pipe.sv
// Read-return realignment: delays each capture strobe by CAP_LAT cycles, then
// registers the IOB word into a valid-qualified output.
module ddr_capture_pipe
  import ddr_data_sequencer_pkg::*;
#(
  parameter int CAP_LAT = 1,
  parameter int W       = IOB_WIDTH
) (
  input  logic         clock_i,
  input  logic         reset_ni,
  input  logic         cap_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic [CAP_LAT-1:0] flag_q, flag_d;
  logic               valid_q, valid_d;
  logic [W-1:0]       data_q, data_d;
  logic               flag_exit;

  assign flag_exit = flag_q[CAP_LAT-1];

  always_comb begin
    flag_d  = (flag_q << 1) | CAP_LAT'(cap_i);
    valid_d = flag_exit;
    data_d  = flag_exit ? data_i : data_q;
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      flag_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      flag_q  <= flag_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/ddr_data_sequencer.sv
// Burst sequencer in front of the DDR data IOBs: write/read bursts, CAS wait,
// one-cycle bus turnaround, and realigned read return.
//
// state      | meaning
// ST_IDLE    | waiting for a request; write wins over read
// ST_WRITE   | BURST cycles acking wr_data_i; send/data follow one cycle later
// ST_RD_WAIT | CAS_LAT-1 cycles before the first capture strobe
// ST_READ    | BURST cycles with capture strobes asserted
// ST_TURN    | one bus turnaround cycle, requests ignored
module ddr_data_sequencer
  import ddr_data_sequencer_pkg::*;
#(
  parameter int BURST   = 2,
  parameter int CAS_LAT = 2,
  parameter int CAP_LAT = 1
) (
  input  logic                 clock_i,
  input  logic                 reset_ni,
  input  logic                 wr_req_i,
  input  logic                 rd_req_i,
  output logic                 busy_o,
  input  logic [IOB_WIDTH-1:0] wr_data_i,
  output logic                 wr_ack_o,
  output logic [IOB_WIDTH-1:0] rd_data_o,
  output logic                 rd_valid_o,
  output logic                 iob_send_o,
  output logic [1:0]           iob_capture_o,
  output logic [IOB_WIDTH-1:0] iob_data_o,
  input  logic [IOB_WIDTH-1:0] iob_data_i
);

  localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam int WW = (CAS_LAT > 2) ? $clog2(CAS_LAT - 1) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(BURST - 1);
  localparam logic [WW-1:0] WAIT_LOAD = WW'((CAS_LAT > 1) ? CAS_LAT - 2 : 0);

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [WW-1:0]          wait_q, wait_d;
  logic                   send_q, send_d;
  logic [IOB_WIDTH-1:0]   iob_data_q, iob_data_d;
  logic                   wr_ack;
  logic                   capture;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wait_d     = wait_q;
    send_d     = 1'b0;
    iob_data_d = iob_data_q;
    wr_ack     = 1'b0;
    capture    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wr_req_i) begin
          state_d = ST_WRITE;
          cnt_d   = '0;
        end else if (rd_req_i) begin
          cnt_d = '0;
          if (CAS_LAT == 1) begin
            state_d = ST_READ;
          end else begin
            state_d = ST_RD_WAIT;
            wait_d  = WAIT_LOAD;
          end
        end
      end
      ST_WRITE: begin
        wr_ack     = 1'b1;
        send_d     = 1'b1;
        iob_data_d = wr_data_i;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_TURN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_RD_WAIT: begin
        // wait_q counts down to terminal count 0, then reads start
        if (wait_q == '0) state_d = ST_READ;
        else              wait_d  = wait_q - WW'(1);
      end
      ST_READ: begin
        capture = 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_TURN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_TURN: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      wait_q     <= '0;
      send_q     <= 1'b0;
      iob_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wait_q     <= wait_d;
      send_q     <= send_d;
      iob_data_q <= iob_data_d;
    end
  end

  assign busy_o        = (state_q != ST_IDLE);
  assign wr_ack_o      = wr_ack;
  assign iob_send_o    = send_q;
  assign iob_data_o    = iob_data_q;
  assign iob_capture_o = {2{capture}};

  ddr_capture_pipe #(
    .CAP_LAT (CAP_LAT),
    .W       (IOB_WIDTH)
  ) u_capture_pipe (
    .clock_i  (clock_i),
    .reset_ni (reset_ni),
    .cap_i    (capture),
    .data_i   (iob_data_i),
    .valid_o  (rd_valid_o),
    .data_o   (rd_data_o)
  );

endmodule

// File: tb/tb_ddr_data_sequencer.sv
// Bench for ddr_data_sequencer: a BURST=2 and a BURST=4 instance share stimulus
// and are checked every cycle against a schedule-based reference model.
module tb_ddr_data_sequencer;

  localparam int CAS = 2;
  localparam int CAP = 1;
  localparam int N   = 1024;

  logic        clock_i = 1'b0;
  logic        reset_n;
  logic        wr_req, rd_req;
  logic [31:0] wr_data;
  logic [31:0] iobi [2];
  logic        busy_w [2], ack_w [2], send_w [2], valid_w [2];
  logic [1:0]  cap_w [2];
  logic [31:0] iobo_w [2], rdd_w [2];

  always #5 clock_i = ~clock_i;

  ddr_data_sequencer #(.BURST(2), .CAS_LAT(CAS), .CAP_LAT(CAP)) dut2 (
    .clock_i(clock_i), .reset_ni(reset_n), .wr_req_i(wr_req), .rd_req_i(rd_req),
    .busy_o(busy_w[0]), .wr_data_i(wr_data), .wr_ack_o(ack_w[0]),
    .rd_data_o(rdd_w[0]), .rd_valid_o(valid_w[0]), .iob_send_o(send_w[0]),
    .iob_capture_o(cap_w[0]), .iob_data_o(iobo_w[0]), .iob_data_i(iobi[0]));

  ddr_data_sequencer #(.BURST(4), .CAS_LAT(CAS), .CAP_LAT(CAP)) dut4 (
    .clock_i(clock_i), .reset_ni(reset_n), .wr_req_i(wr_req), .rd_req_i(rd_req),
    .busy_o(busy_w[1]), .wr_data_i(wr_data), .wr_ack_o(ack_w[1]),
    .rd_data_o(rdd_w[1]), .rd_valid_o(valid_w[1]), .iob_send_o(send_w[1]),
    .iob_capture_o(cap_w[1]), .iob_data_o(iobo_w[1]), .iob_data_i(iobi[1]));

  // expected per-cycle schedule, filled when the model accepts a request
  bit          exp_busy [2][N];
  bit          exp_ack  [2][N];
  bit          exp_send [2][N];
  bit          exp_cap  [2][N];
  bit          exp_vld  [2][N];
  logic [31:0] iobd_at  [2][N];
  logic [31:0] rdw_at   [2][N];
  logic [31:0] last_iobd [2];
  logic [31:0] last_rd   [2];
  int          free_c [2];
  int          acc_wr [2];
  int          acc_rd [2];
  int          vcnt1;
  int          cyc;
  bit          in_reset;
  logic [31:0] wq [$];
  logic [31:0] rq [$];
  int          checks, failures;

  function automatic int blen(int i);
    return (i == 0) ? 2 : 4;
  endfunction

  task automatic chk(string tag, int i, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s inst=%0d cyc=%0d got=%h exp=%h", tag, i, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int k = cyc + 1; k < N; k++) begin
        exp_busy[i][k] = 0; exp_ack[i][k] = 0; exp_send[i][k] = 0;
        exp_cap[i][k]  = 0; exp_vld[i][k] = 0;
      end
      last_iobd[i] = '0;
      last_rd[i]   = '0;
      free_c[i]    = 0;
    end
  endtask

  task automatic step();
    logic [31:0] w;
    int b;
    if (cyc > N - 32) begin
      $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, N - 32);
      $fatal(1, "cycle budget exhausted");
    end
    wr_data = (!in_reset && exp_ack[0][cyc] && wq.size() > 0) ? wq.pop_front() : $urandom();
    for (int i = 0; i < 2; i++) begin
      if (!in_reset && exp_ack[i][cyc]) iobd_at[i][cyc+1] = wr_data;
      if (!in_reset && cyc >= CAP && exp_cap[i][cyc-CAP]) begin
        w = (i == 0 && rq.size() > 0) ? rq.pop_front() : $urandom();
        iobi[i] = w;
        rdw_at[i][cyc+1]  = w;
        exp_vld[i][cyc+1] = 1;
      end else begin
        iobi[i] = $urandom();
      end
      b = blen(i);
      if (!in_reset && cyc >= free_c[i] && (wr_req || rd_req)) begin
        if (wr_req) begin
          for (int j = 0; j < b; j++) begin
            exp_ack[i][cyc+1+j]  = 1;
            exp_send[i][cyc+2+j] = 1;
          end
          for (int j = 1; j <= b + 1; j++) exp_busy[i][cyc+j] = 1;
          free_c[i] = cyc + b + 2;
          acc_wr[i]++;
        end else begin
          for (int j = 0; j < b; j++) exp_cap[i][cyc+CAS+j] = 1;
          for (int j = 1; j <= CAS + b; j++) exp_busy[i][cyc+j] = 1;
          free_c[i] = cyc + CAS + b + 1;
          acc_rd[i]++;
        end
      end
    end
    @(posedge clock_i);
    #1;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (exp_send[i][cyc]) last_iobd[i] = iobd_at[i][cyc];
      if (exp_vld[i][cyc])  last_rd[i]   = rdw_at[i][cyc];
      chk("busy",     i, 32'(busy_w[i]),  32'(exp_busy[i][cyc]));
      chk("wr_ack",   i, 32'(ack_w[i]),   32'(exp_ack[i][cyc]));
      chk("send",     i, 32'(send_w[i]),  32'(exp_send[i][cyc]));
      chk("capture",  i, 32'(cap_w[i]),   32'({2{exp_cap[i][cyc]}}));
      chk("iob_data", i, iobo_w[i],       last_iobd[i]);
      chk("rd_valid", i, 32'(valid_w[i]), 32'(exp_vld[i][cyc]));
      chk("rd_data",  i, rdd_w[i],        last_rd[i]);
    end
    if (valid_w[1] === 1'b1) vcnt1++;
  endtask

  initial begin
    int g, base;
    checks = 0; failures = 0; cyc = 0; vcnt1 = 0;
    wr_req = 0; rd_req = 0; wr_data = '0; iobi[0] = '0; iobi[1] = '0;
    for (int i = 0; i < 2; i++) begin
      acc_wr[i] = 0; acc_rd[i] = 0;
    end
    reset_n = 0; in_reset = 1;
    model_reset();

    // reset, then 20 quiet cycles
    repeat (3) step();
    reset_n = 1; in_reset = 0;
    repeat (20) step();

    // directed write burst
    wq.push_back(32'hFFAA_0033);
    wq.push_back(32'h1234_5678);
    wr_req = 1;
    step();
    wr_req = 0;
    repeat (10) step();

    // directed read burst with known return words
    rq.push_back(32'hDEAD_BEEF);
    rq.push_back(32'hCAFE_F00D);
    rd_req = 1;
    step();
    rd_req = 0;
    repeat (12) step();

    // both requests high: write first, then the read after turnaround
    base = acc_rd[0];
    wr_req = 1; rd_req = 1;
    step();
    wr_req = 0;
    g = 0;
    while (acc_rd[0] == base && g < 60) begin step(); g++; end
    chk("rd_after_wr_timeout", 0, 32'(g < 60), 32'd1);
    rd_req = 0;
    repeat (15) step();

    // reset during the second READ cycle of the BURST=2 instance
    rd_req = 1;
    step();
    rd_req = 0;
    repeat (CAS) step();
    #2;
    reset_n = 0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_capture", i, 32'(cap_w[i]),   32'd0);
      chk("rst_valid",   i, 32'(valid_w[i]), 32'd0);
      chk("rst_busy",    i, 32'(busy_w[i]),  32'd0);
    end
    in_reset = 1;
    model_reset();
    repeat (3) step();
    reset_n = 1; in_reset = 0;
    repeat (3) step();
    rd_req = 1;
    step();
    rd_req = 0;
    repeat (15) step();

    // back-to-back reads on the BURST=4 instance: two bursts, eight words
    vcnt1 = 0;
    base = acc_rd[1];
    rd_req = 1;
    g = 0;
    while (acc_rd[1] < base + 2 && g < 60) begin step(); g++; end
    chk("b2b_timeout", 1, 32'(g < 60), 32'd1);
    rd_req = 0;
    repeat (20) step();
    chk("b2b_valid_count", 1, 32'(vcnt1), 32'd8);

    // randomized requests and data
    for (int n = 0; n < 400; n++) begin
      wr_req = ($urandom_range(0, 3) == 0);
      rd_req = ($urandom_range(0, 2) == 0);
      step();
    end
    wr_req = 0; rd_req = 0;
    repeat (20) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
